// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative limb multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } mult_state_t;

    localparam int DW_DEFAULT = 128;
    localparam int LW_DEFAULT = 16;

    function automatic int limbs(input int dw, input int lw);
        return dw / lw;
    endfunction

endpackage

// File: rtl/mult_iter_row.sv
// One row of K limb multipliers: row = a * b with b a single limb, one cycle of latency.
module mult_iter_row
    import mult_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int LW = LW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    a,
    input  logic [LW-1:0]    b,
    output logic [DW+LW-1:0] row
);
    localparam int K  = limbs(DW, LW);
    localparam int RW = DW + LW;

    logic [K-1:0][LW-1:0]   a_limb;
    logic [K-1:0][2*LW-1:0] prod;
    logic [RW-1:0]          row_d;
    logic [RW-1:0]          row_q;

    assign a_limb = a;

    always_comb begin
        prod  = '0;
        row_d = '0;
        for (int k = 0; k < K; k++) begin
            prod[k] = {LW'(0), a_limb[k]} * {LW'(0), b};
            row_d   = row_d + (RW'(prod[k]) << (k * LW));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    assign row = row_q;

endmodule

// File: rtl/mult_iter.sv
// Iterative multiplier: one limb row reused over K cycles, product presented as {carry, ret}.
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | limb y_j fed to the row, earlier rows accumulated
// DRAIN | last row accumulated, sign applied
// DONE  | product held on {carry, ret} until out_ready
module mult_iter
    import mult_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int LW = LW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    input  logic          sgn,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] ret,
    output logic [DW-1:0] carry
);
    localparam int K  = limbs(DW, LW);
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int RW = DW + LW;
    localparam int AW = 2 * DW;

    if (DW % LW != 0) begin : g_bad_dw
        $error("mult_iter: DW must be a multiple of LW");
    end
    if (K < 2) begin : g_bad_k
        $error("mult_iter: at least two limbs are required");
    end

    mult_state_t          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]        ax_q, ax_d;
    logic [K-1:0][LW-1:0] ay_q, ay_d;
    logic                 neg_q, neg_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic                 row_vld_q, row_vld_d;
    logic [CW-1:0]        row_idx_q, row_idx_d;
    logic [RW-1:0]        row;
    logic [AW-1:0]        acc_sum;

    mult_iter_row #(
        .DW(DW),
        .LW(LW)
    ) u_row (
        .clk (clk),
        .rst (rst),
        .a   (ax_q),
        .b   (ay_q[cnt_q]),
        .row (row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ax_q      <= '0;
            ay_q      <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            row_vld_q <= 1'b0;
            row_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ax_q      <= ax_d;
            ay_q      <= ay_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            row_vld_q <= row_vld_d;
            row_idx_q <= row_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ax_d      = ax_q;
        ay_d      = ay_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        row_vld_d = 1'b0;
        row_idx_d = cnt_q;
        // The row register lags the limb counter by one cycle, so its weight is tracked separately.
        acc_sum   = acc_q + (AW'(row) << (int'(row_idx_q) * LW));

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ax_d    = (sgn && x[DW-1]) ? -x : x;
                    ay_d    = (sgn && y[DW-1]) ? -y : y;
                    neg_d   = sgn & (x[DW-1] ^ y[DW-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                row_vld_d = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (row_vld_q) begin
                    acc_d = acc_sum;
                end
                if (cnt_q == CW'(K - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                acc_d   = neg_q ? -acc_sum : acc_sum;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign ret       = acc_q[DW-1:0];
    assign carry     = acc_q[AW-1:DW];

endmodule

// File: tb/tb_mult_iter.sv
// Bench for mult_iter (DW=128, LW=16): directed vectors plus a cycle-level reference model.
module tb_mult_iter;
    localparam int DW  = 128;
    localparam int LAT = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x, y;
    logic          sgn;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] ret, carry;

    logic          auto_ready;
    logic          rdy_rand;
    logic          rdy_man;

    int checks  = 0;
    int errors  = 0;
    int ops_sent = 0;
    int aborted = 0;

    bit            m_busy  = 1'b0;
    bit            m_fresh = 1'b1;
    int            m_age   = 0;
    logic [255:0]  m_prod  = '0;
    int            n_acc   = 0;
    int            n_done  = 0;
    int            dut_done = 0;

    localparam logic [DW-1:0] MIN_NEG = {1'b1, 127'b0};

    always #5 clk = ~clk;

    assign out_ready = auto_ready ? rdy_rand : rdy_man;

    mult_iter #(
        .DW(128),
        .LW(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ret       (ret),
        .carry     (carry)
    );

    function automatic logic [255:0] ref_mul(input logic [127:0] a, input logic [127:0] b,
                                             input logic s);
        logic signed [255:0] sa, sb;
        if (s) begin
            sa = {{128{a[127]}}, a};
            sb = {{128{b[127]}}, b};
            return sa * sb;
        end
        return {128'b0, a} * {128'b0, b};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] rand_op();
        logic [127:0] v;
        v = '0;
        case ($urandom_range(0, 9))
            0:       v = '0;
            1:       v[$urandom_range(0, 127)] = 1'b1;
            2:       v = '1;
            3:       v = MIN_NEG;
            default: v = rand128();
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle model: outputs for the current cycle, then the effect of the coming edge.
    always @(negedge clk) begin : cmp
        logic exp_ov;
        exp_ov = m_busy && (m_age >= LAT);
        check("in_ready", 256'(in_ready), 256'(!m_busy));
        check("out_valid", 256'(out_valid), 256'(exp_ov));
        if (exp_ov) check("product", {carry, ret}, m_prod);
        if (!m_busy && m_fresh) check("idle_zero", {carry, ret}, '0);

        if (rst) begin
            m_busy  = 1'b0;
            m_fresh = 1'b1;
            m_age   = 0;
        end else begin
            if (out_valid && out_ready) dut_done++;
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy  = 1'b1;
                    m_age   = 0;
                    m_fresh = 1'b0;
                    m_prod  = ref_mul(x, y, sgn);
                    n_acc++;
                end
            end else if (exp_ov && out_ready) begin
                m_busy = 1'b0;
                n_done++;
            end else begin
                m_age++;
            end
        end
    end

    initial begin
        rdy_rand = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy_rand = ($urandom_range(0, 99) < 65);
        end
    end

    task automatic send(input logic [127:0] a, input logic [127:0] b, input logic s,
                        input int gap);
        bit got;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        x        = a;
        y        = b;
        sgn      = s;
        ops_sent++;
        got = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = rand128();
        y        = rand128();
        sgn      = ($urandom_range(0, 1) != 0);
    endtask

    // Returns at the negedge where out_valid is first seen; lat counts edges after acceptance.
    task automatic wait_out(input string name, output int lat);
        bit found;
        found = 1'b0;
        lat   = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            lat++;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: out_valid stayed 0, required 1", name);
        end
    endtask

    task automatic send_check(input string name, input logic [127:0] a, input logic [127:0] b,
                              input logic s, input logic [127:0] ec, input logic [127:0] er);
        int lat;
        rdy_man = 1'b1;
        send(a, b, s, 0);
        wait_out(name, lat);
        check({name, "_lat"}, 256'(lat), 256'(LAT));
        check({name, "_carry"}, 256'(carry), 256'(ec));
        check({name, "_ret"}, 256'(ret), 256'(er));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        rst        = 1'b1;
        in_valid   = 1'b0;
        x          = '0;
        y          = '0;
        sgn        = 1'b0;
        auto_ready = 1'b0;
        rdy_man    = 1'b1;

        check("pin_umax", ref_mul('1, '1, 1'b0),
              {{127{1'b1}}, 1'b0, {127{1'b0}}, 1'b1});
        check("pin_s_m1x3", ref_mul('1, 128'd3, 1'b1), {{254{1'b1}}, 2'b01});
        check("pin_u_m1x3", ref_mul('1, 128'd3, 1'b0), {128'd2, {126{1'b1}}, 2'b01});
        check("pin_minsq", ref_mul(MIN_NEG, MIN_NEG, 1'b1), {2'b01, 254'b0});
        check("pin_minx1", ref_mul(MIN_NEG, 128'd1, 1'b1), {{129{1'b1}}, 127'b0});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        send_check("umax", '1, '1, 1'b0, {{127{1'b1}}, 1'b0}, 128'd1);
        send_check("s_m1x3", '1, 128'd3, 1'b1, '1, {{126{1'b1}}, 2'b01});
        send_check("u_m1x3", '1, 128'd3, 1'b0, 128'd2, {{126{1'b1}}, 2'b01});
        send_check("s_minsq", MIN_NEG, MIN_NEG, 1'b1, {2'b01, 126'b0}, 128'd0);
        send_check("s_minx1", MIN_NEG, 128'd1, 1'b1, '1, MIN_NEG);

        // Backpressure, with the next request already waiting during DONE.
        rdy_man = 1'b0;
        send(128'd1234, 128'd5678, 1'b0, 0);
        wait_out("bp", lat);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 256'(out_valid), 256'(1));
            check("bp_in_ready", 256'(in_ready), 256'(0));
            check("bp_prod", {carry, ret}, 256'd7006652);
        end
        @(posedge clk);
        #1;
        rdy_man  = 1'b1;
        in_valid = 1'b1;
        x        = 128'd9;
        y        = 128'd11;
        sgn      = 1'b0;
        ops_sent++;
        @(negedge clk);
        check("bp_last_valid", 256'(out_valid), 256'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_ready_back", 256'(in_ready), 256'(1));
        check("bp_valid_drop", 256'(out_valid), 256'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_reaccept", 256'(in_ready), 256'(0));
        wait_out("bp2", lat);
        check("bp2_ret", 256'(ret), 256'd99);
        @(posedge clk);
        #1;

        // Reset while the limb counter is at 3.
        send(rand128(), rand128(), 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        aborted++;
        @(negedge clk);
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_ret", 256'(ret), 256'(0));
        check("rst_carry", 256'(carry), 256'(0));
        @(posedge clk);
        #1;
        send_check("after_rst", 128'd5, 128'd7, 1'b0, 128'd0, 128'd35);

        auto_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            send(rand_op(), rand_op(), ($urandom_range(0, 1) != 0), $urandom_range(0, 2));
        end

        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (!m_busy) break;
        end
        @(posedge clk);
        #1;
        check("model_done", 256'(n_done), 256'(ops_sent - aborted));
        check("dut_done", 256'(dut_done), 256'(n_done));
        check("accepts", 256'(n_acc), 256'(ops_sent));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
